// File: rtl/keypad_entry.sv
// Keypad digit-entry controller: requests scans, edge-detects key_ready, accumulates a decimal entry.
// Optional idle-entry timeout enabled with `define ENTRY_TIMEOUT_EN.
module keypad_entry #(
  parameter int unsigned MAX_DIGITS     = 4,
  parameter int unsigned VALUE_W        = 14,
  parameter int unsigned TIMEOUT_CYCLES = 125000000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [3:0]         key_code,
  input  logic               key_ready,
  output logic               scan,
  output logic [VALUE_W-1:0] entry_value,
  output logic [2:0]         digit_count,
  output logic [VALUE_W-1:0] value_out,
  output logic               value_valid,
  output logic               overflow,
  output logic               timeout
);

  localparam int unsigned CNT_W = 27;
  localparam logic [3:0]  KEY_CLEAR = 4'hA;
  localparam logic [3:0]  KEY_ENTER = 4'hB;

  // Parameter sanity: the counter is 27 bits and digit_count is 3 bits.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > (1 << CNT_W) || MAX_DIGITS > 7) begin : g_bad_param
    $error("keypad_entry: parameter out of range");
  end

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_PROC} state_t;

  state_t               state, state_nxt;
  logic                 key_ready_d;
  logic                 key_rise_c;
  logic [3:0]           key_q, key_q_nxt;
  logic                 scan_nxt;
  logic [VALUE_W-1:0]   entry_nxt, vout_nxt;
  logic [2:0]           count_nxt;
  logic                 valid_nxt, ovf_nxt;
`ifdef ENTRY_TIMEOUT_EN
  logic [CNT_W-1:0]     idle_cnt, cnt_nxt;
  logic                 timeout_nxt;
`endif

  assign key_rise_c = key_ready & ~key_ready_d;

  // Next-state and next-output logic
  always_comb begin
    state_nxt = state;
    scan_nxt  = 1'b0;
    key_q_nxt = key_q;
    entry_nxt = entry_value;
    count_nxt = digit_count;
    vout_nxt  = value_out;
    valid_nxt = 1'b0;
    ovf_nxt   = overflow;
`ifdef ENTRY_TIMEOUT_EN
    timeout_nxt = 1'b0;
    cnt_nxt     = '0;
`endif
    unique case (state)
      S_REQ: begin
        if (enable) begin
          scan_nxt  = 1'b1;
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (key_rise_c) begin
          key_q_nxt = key_code;
          state_nxt = S_PROC;
        end
`ifdef ENTRY_TIMEOUT_EN
        // Abandon a partial entry after TIMEOUT_CYCLES idle cycles
        else if (digit_count != 3'd0) begin
          if (idle_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            entry_nxt   = '0;
            count_nxt   = 3'd0;
            ovf_nxt     = 1'b0;
            timeout_nxt = 1'b1;
          end else begin
            cnt_nxt = idle_cnt + CNT_W'(1);
          end
        end
`endif
      end
      S_PROC: begin
        state_nxt = S_REQ;
        if (key_q <= 4'd9) begin
          if (digit_count < 3'(MAX_DIGITS)) begin
            entry_nxt = (entry_value << 3) + (entry_value << 1) + VALUE_W'(key_q);
            count_nxt = digit_count + 3'd1;
          end else begin
            ovf_nxt = 1'b1;
          end
        end else if (key_q == KEY_CLEAR) begin
          entry_nxt = '0;
          count_nxt = 3'd0;
          ovf_nxt   = 1'b0;
        end else if (key_q == KEY_ENTER && digit_count != 3'd0) begin
          vout_nxt  = entry_value;
          valid_nxt = 1'b1;
          entry_nxt = '0;
          count_nxt = 3'd0;
          ovf_nxt   = 1'b0;
        end
      end
      default: state_nxt = S_REQ;
    endcase
  end

  // State and output registers; key_ready_d tracks key_ready even in reset
  always_ff @(posedge clk) begin
    key_ready_d <= key_ready;
    if (!rst_n) begin
      state       <= S_REQ;
      key_q       <= 4'd0;
      scan        <= 1'b0;
      entry_value <= '0;
      digit_count <= 3'd0;
      value_out   <= '0;
      value_valid <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      state       <= state_nxt;
      key_q       <= key_q_nxt;
      scan        <= scan_nxt;
      entry_value <= entry_nxt;
      digit_count <= count_nxt;
      value_out   <= vout_nxt;
      value_valid <= valid_nxt;
      overflow    <= ovf_nxt;
    end
  end

`ifdef ENTRY_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idle_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      idle_cnt <= cnt_nxt;
      timeout  <= timeout_nxt;
    end
  end
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_keypad_entry.sv
// Bench for keypad_entry: scanner-side driver, integer entry model checked every cycle,
// and literal expectations at key points. Honours `define ENTRY_TIMEOUT_EN.
module tb_keypad_entry;

  localparam int unsigned VW = 14;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic [3:0]    key_code;
  logic          key_ready;
  logic          scan;
  logic [VW-1:0] entry_value;
  logic [2:0]    digit_count;
  logic [VW-1:0] value_out;
  logic          value_valid;
  logic          overflow;
  logic          timeout;

  keypad_entry #(.MAX_DIGITS(4), .VALUE_W(VW), .TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .key_code(key_code), .key_ready(key_ready),
    .scan(scan), .entry_value(entry_value), .digit_count(digit_count), .value_out(value_out),
    .value_valid(value_valid), .overflow(overflow), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Behavioural model of the entry
  int m_entry = 0, m_count = 0, m_vout = 0, m_valid = 0, m_ovf = 0, m_timeout = 0;
  bit chk_en = 0;
  bit outstanding = 0;
  bit prev_scan = 0;
  int pulses = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply(input int k);
    if (k <= 9) begin
      if (m_count < 4) begin
        m_entry = m_entry * 10 + k;
        m_count++;
      end else m_ovf = 1;
    end else if (k == 10) begin
      m_entry = 0; m_count = 0; m_ovf = 0;
    end else if (k == 11 && m_count > 0) begin
      m_vout = m_entry; m_valid = 1;
      m_entry = 0; m_count = 0; m_ovf = 0;
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("entry_value", int'(entry_value), m_entry);
      check("digit_count", int'(digit_count), m_count);
      check("value_out", int'(value_out), m_vout);
      check("value_valid", int'(value_valid), m_valid);
      check("overflow", int'(overflow), m_ovf);
      check("timeout", int'(timeout), m_timeout);
      if (value_valid) pulses++;
      if (scan) begin
        outstanding = 1;
        check("scan_width", int'(prev_scan), 0);
      end
      prev_scan = scan;
    end
  end

  // Scanner side: wait for a scan request, then present one fresh key press
  task automatic press(input logic [3:0] k, input bit drop_en);
    int n;
    n = 0;
    @(negedge clk);
    key_ready = 1'b0;
    while (!outstanding && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!outstanding) check("scan_wait", 0, 1);
    @(negedge clk);
    @(negedge clk);
    key_code = k;
    key_ready = 1'b1;
    outstanding = 0;
    if (drop_en) enable = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    apply(int'(k));
    @(posedge clk); #1;
    m_valid = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    key_ready = 1'b0;
    outstanding = 0;
    @(posedge clk); #1;
    m_entry = 0; m_count = 0; m_vout = 0; m_valid = 0; m_ovf = 0; m_timeout = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int p0;
    rst_n = 1'b0; enable = 1'b1; key_code = 4'd0; key_ready = 1'b0;
    @(posedge clk); #1;
    chk_en = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_scan", int'(scan), 0);
    check("rst_value_out", int'(value_out), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("first_scan", int'(scan), 1);

    // 1,2,3,E commits 123
    press(4'd1, 0); press(4'd2, 0); press(4'd3, 0);
    check("entry_12_3", int'(entry_value), 123);
    press(4'hB, 0);
    @(negedge clk);
    check("commit_123", int'(value_out), 123);
    check("commit_entry_clr", int'(entry_value), 0);
    check("pulses_1", pulses, 1);

    // 9,9,9,9,5 overflows, C clears
    press(4'd9, 0); press(4'd9, 0); press(4'd9, 0); press(4'd9, 0); press(4'd5, 0);
    @(negedge clk);
    check("full_9999", int'(entry_value), 9999);
    check("full_count", int'(digit_count), 4);
    check("full_ovf", int'(overflow), 1);
    press(4'hA, 0);
    @(negedge clk);
    check("clear_ovf", int'(overflow), 0);

    // E on empty entry ignored; 0,E commits zero
    press(4'hB, 0);
    @(negedge clk);
    check("empty_enter", pulses, 1);
    press(4'd0, 0);
    check("zero_count", int'(digit_count), 1);
    press(4'hB, 0);
    @(negedge clk);
    check("commit_zero", int'(value_out), 0);
    check("pulses_2", pulses, 2);

    // Key 4 held high across a new scan, then an invalid code
    press(4'd4, 0);
    repeat (20) @(negedge clk);
    check("held_entry", int'(entry_value), 4);
    check("held_count", int'(digit_count), 1);
    press(4'hF, 0);
    @(negedge clk);
    check("invalid_key", int'(entry_value), 4);

    // enable low in REQ holds off scanning
    press(4'd5, 1);
    p0 = 0;
    repeat (10) begin
      @(negedge clk);
      check("scan_off", int'(scan), 0);
      p0++;
    end
    check("entry_45", int'(entry_value), 45);
    enable = 1'b1;
    @(negedge clk);
    check("scan_on", int'(scan), 1);
    press(4'hA, 0);

    // Reset mid-entry clears entry and committed value
    press(4'd8, 0); press(4'hB, 0);
    press(4'd5, 0); press(4'd6, 0);
    @(negedge clk);
    check("pre_reset_vout", int'(value_out), 8);
    do_reset();
    @(negedge clk);
    check("post_reset_entry", int'(entry_value), 0);
    check("post_reset_vout", int'(value_out), 0);

    // Idle partial entry
    press(4'd7, 0);
    @(negedge clk);
    check("idle_scan", int'(scan), 1);
    repeat (100) @(posedge clk);
    #1;
`ifdef ENTRY_TIMEOUT_EN
    m_entry = 0; m_count = 0; m_ovf = 0; m_timeout = 1;
`endif
    @(posedge clk); #1;
    m_timeout = 0;
    repeat (5) @(negedge clk);
`ifdef ENTRY_TIMEOUT_EN
    check("idle_entry", int'(entry_value), 0);
`else
    check("idle_entry", int'(entry_value), 7);
`endif

    chk_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
